// File: rtl/qsched_pkg.sv
// Shared types for the quantizer scheduler.
// Channel tags, block type, FIFO entry, defaults.
package qsched_pkg;

  typedef enum logic [1:0] {
    CH_Y  = 2'd0,
    CH_CB = 2'd1,
    CH_CR = 2'd2
  } chan_t;

  typedef logic signed [0:7][0:7][10:0] qblk_t;

  typedef struct packed {
    chan_t chan;
    qblk_t blk;
  } qent_t;

  localparam int QLAT_DEFAULT = 4;
  localparam int MAX_INFLIGHT_DEFAULT = 2;

  function automatic chan_t chan_next(chan_t c);
    chan_t n;
    unique case (c)
      CH_Y:    n = CH_CB;
      CH_CB:   n = CH_CR;
      default: n = CH_Y;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qsched_if.sv
// Requester, quantizer and result bundle of quant_scheduler.
// slave = scheduler view, master = environment view.
interface qsched_if;
  import qsched_pkg::*;

  logic  y_valid, cb_valid, cr_valid;
  logic  y_ready, cb_ready, cr_ready;
  qblk_t y_blk, cb_blk, cr_blk;
  logic  qz_enable;
  chan_t qz_sel;
  qblk_t qz_blk;
  logic  qz_out_enable;
  qblk_t qz_q;
  logic  out_valid, out_ready;
  chan_t out_chan;
  qblk_t out_blk;
  logic  busy, err;

  modport slave (
    input  y_valid, cb_valid, cr_valid,
    input  y_blk, cb_blk, cr_blk,
    input  qz_out_enable, qz_q, out_ready,
    output y_ready, cb_ready, cr_ready,
    output qz_enable, qz_sel, qz_blk,
    output out_valid, out_chan, out_blk,
    output busy, err
  );

  modport master (
    output y_valid, cb_valid, cr_valid,
    output y_blk, cb_blk, cr_blk,
    output qz_out_enable, qz_q, out_ready,
    input  y_ready, cb_ready, cr_ready,
    input  qz_enable, qz_sel, qz_blk,
    input  out_valid, out_chan, out_blk,
    input  busy, err
  );

endinterface

// File: rtl/qsched_blk_fifo.sv
// Small result FIFO, DEPTH 1..4, push+pop same cycle.
// Output word comes straight from the storage registers.
module qsched_blk_fifo
  import qsched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_push,
  input  qent_t i_data,
  input  logic  i_pop,
  output logic  o_valid,
  output qent_t o_data
);

  qent_t      r_mem [4];
  logic [1:0] r_wp;
  logic [1:0] r_rp;
  logic [2:0] r_cnt;
  logic       w_pop;

  function automatic logic [1:0] nxt(logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_pop   = i_pop & (r_cnt != 3'd0);
  assign o_valid = (r_cnt != 3'd0);
  assign o_data  = r_mem[r_rp];

  // storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= nxt(r_wp);
      end
      if (w_pop) r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + {2'b0, i_push} - {2'b0, w_pop};
    end
  end

endmodule

// File: rtl/quant_scheduler.sv
// Shares one quantizer among Y/Cb/Cr with credit flow.
// Define QSCHED_MCU420_EN for fixed Y,Y,Y,Y,Cb,Cr order.
module quant_scheduler
  import qsched_pkg::*;
#(
  parameter int QLAT         = QLAT_DEFAULT,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
  input logic     clk,
  input logic     rst,
  qsched_if.slave bus
);

  logic [2:0]  w_vld;
  logic [2:0]  r_credit;
  logic        w_pop, w_room, w_hit, w_acc;
  logic        w_tail, w_push, w_rel;
  chan_t       w_gch;
  qblk_t       w_blk;
  logic        r_qz_en;
  chan_t       r_qz_sel;
  qblk_t       r_qz_blk;
  logic [QLAT:0] r_tv;
  chan_t       r_tc [QLAT+1];
  logic        r_err;
  qent_t       w_fo;

  assign w_vld  = {bus.cr_valid, bus.cb_valid, bus.y_valid};
  assign w_pop  = bus.out_valid & bus.out_ready;
  assign w_room = (r_credit < 3'(MAX_INFLIGHT)) | w_pop;
  assign w_acc  = w_hit & w_room & ~rst;

`ifdef QSCHED_MCU420_EN
  logic [2:0] r_seq;

  // only the channel due in the MCU sequence may win
  always_comb begin
    w_gch = CH_CR;
    unique case (1'b1)
      (r_seq < 3'd4):  w_gch = CH_Y;
      (r_seq == 3'd4): w_gch = CH_CB;
      default:         w_gch = CH_CR;
    endcase
    w_hit = w_vld[w_gch];
  end

  // sequence position advances per grant
  always_ff @(posedge clk) begin
    if (rst) r_seq <= 3'd0;
    else if (w_acc) r_seq <= (r_seq == 3'd5) ? 3'd0 : r_seq + 3'd1;
  end
`else
  chan_t r_ptr;
  chan_t w_c1, w_c2;

  assign w_c1 = chan_next(r_ptr);
  assign w_c2 = chan_next(w_c1);

  // round-robin search starting at the pointer
  always_comb begin
    w_hit = 1'b1;
    w_gch = r_ptr;
    if (w_vld[r_ptr])     w_gch = r_ptr;
    else if (w_vld[w_c1]) w_gch = w_c1;
    else if (w_vld[w_c2]) w_gch = w_c2;
    else                  w_hit = 1'b0;
  end

  // pointer moves past the winner
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= CH_Y;
    else if (w_acc) r_ptr <= chan_next(w_gch);
  end
`endif

  assign bus.y_ready  = w_acc & (w_gch == CH_Y);
  assign bus.cb_ready = w_acc & (w_gch == CH_CB);
  assign bus.cr_ready = w_acc & (w_gch == CH_CR);

  // block of the winning channel
  always_comb begin
    w_blk = bus.y_blk;
    unique case (1'b1)
      (w_gch == CH_CB): w_blk = bus.cb_blk;
      (w_gch == CH_CR): w_blk = bus.cr_blk;
      default:          w_blk = bus.y_blk;
    endcase
  end

  // issue register toward the quantizer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_qz_en  <= 1'b0;
      r_qz_sel <= CH_Y;
      r_qz_blk <= '0;
    end else begin
      r_qz_en <= w_acc;
      if (w_acc) begin
        r_qz_sel <= w_gch;
        r_qz_blk <= w_blk;
      end
    end
  end

  assign w_tail = r_tv[QLAT];
  assign w_push = w_tail & bus.qz_out_enable;
  assign w_rel  = w_tail & ~bus.qz_out_enable;

  // tag pipe mirrors the quantizer latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tv <= '0;
      for (int i = 0; i <= QLAT; i++) r_tc[i] <= CH_Y;
    end else begin
      r_tv    <= {r_tv[QLAT-1:0], w_acc};
      r_tc[0] <= w_gch;
      for (int i = 1; i <= QLAT; i++) r_tc[i] <= r_tc[i-1];
    end
  end

  // credits: issue takes one, pop or lost result returns one
  always_ff @(posedge clk) begin
    if (rst) r_credit <= 3'd0;
    else r_credit <= r_credit + 3'(w_acc)
                   - 3'(w_pop) - 3'(w_rel);
  end

  // sticky strobe/tag disagreement
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else r_err <= r_err | (w_tail ^ bus.qz_out_enable);
  end

  qsched_blk_fifo #(.DEPTH(MAX_INFLIGHT)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_tc[QLAT], bus.qz_q}),
    .i_pop   (w_pop),
    .o_valid (bus.out_valid),
    .o_data  (w_fo)
  );

  assign bus.out_chan  = w_fo.chan;
  assign bus.out_blk   = w_fo.blk;
  assign bus.qz_enable = r_qz_en;
  assign bus.qz_sel    = r_qz_sel;
  assign bus.qz_blk    = r_qz_blk;
  assign bus.busy      = (r_credit != 3'd0);
  assign bus.err       = r_err;

endmodule
